// File: rtl/cache_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_rr_arbiter_if
// Bundles every bus signal of the cache round-robin arbiter: the packed
// requester side, the victim-cache lookup port and the L2 memory port.
// Signal suffixes (_i/_o) are named from the arbiter's point of view.
//   slave  : arbiter side (drives responses, lookups and memory requests)
//   master : environment side (requesters, victim cache, L2)
// ---------------------------------------------------------------------------
interface cache_rr_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128
);
  // requester side
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_rw_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        rsp_ready_o;
  logic [DATA_W-1:0]         rsp_data_o;
  logic [NUM_REQ-1:0]        grant_o;
  // victim-cache lookup port
  logic                      vc_req_valid_o;
  logic [ADDR_W-1:0]         vc_req_addr_o;
  logic                      vc_miss_i;
  logic [DATA_W-1:0]         vc_rsp_data_i;
  // L2 memory port
  logic                      mem_req_valid_o;
  logic                      mem_req_rw_o;
  logic [ADDR_W-1:0]         mem_req_addr_o;
  logic [DATA_W-1:0]         mem_req_data_o;
  logic                      mem_rsp_ready_i;
  logic [DATA_W-1:0]         mem_rsp_data_i;

  modport slave (
    input  req_valid_i, req_rw_i, req_addr_i, req_data_i,
    input  vc_miss_i, vc_rsp_data_i, mem_rsp_ready_i, mem_rsp_data_i,
    output rsp_ready_o, rsp_data_o, grant_o,
    output vc_req_valid_o, vc_req_addr_o,
    output mem_req_valid_o, mem_req_rw_o, mem_req_addr_o, mem_req_data_o
  );

  modport master (
    output req_valid_i, req_rw_i, req_addr_i, req_data_i,
    output vc_miss_i, vc_rsp_data_i, mem_rsp_ready_i, mem_rsp_data_i,
    input  rsp_ready_o, rsp_data_o, grant_o,
    input  vc_req_valid_o, vc_req_addr_o,
    input  mem_req_valid_o, mem_req_rw_o, mem_req_addr_o, mem_req_data_o
  );
endinterface

// File: rtl/cache_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cache_rr_arbiter
// Round-robin arbiter that funnels NUM_REQ L1 requesters onto one L2 port,
// optionally probing a victim cache before memory for reads.
// Ports:
//   clk_i        : single clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   bus          : cache_rr_arbiter_if.slave (requesters, victim cache, L2)
//   vc_hit_cnt_o : saturating 16-bit victim-cache hit counter
// Flow: IDLE grants the first valid requester at/after rr_ptr and latches its
// request; reads go to VC_LOOKUP (one cycle) when VC_EN=1, everything else
// (and VC misses) goes to MEM until the L2 completes.
// ---------------------------------------------------------------------------
module cache_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int OFF_W   = 4,
  parameter int VC_EN   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  cache_rr_arbiter_if.slave    bus,
  output logic [15:0]          vc_hit_cnt_o
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, VC_LOOKUP, MEM} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [15:0]         vc_hit_cnt_q, vc_hit_cnt_d;

  // Unpacked views of the packed requester buses.
  logic [ADDR_W-1:0]   req_addr [NUM_REQ];
  logic [DATA_W-1:0]   req_data [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_addr[gi] = bus.req_addr_i[gi*ADDR_W +: ADDR_W];
    assign req_data[gi] = bus.req_data_i[gi*DATA_W +: DATA_W];
  end

  // Round-robin pick: scan offsets from high to low so the lowest offset
  // from rr_ptr (the nearest valid requester going upward) wins last.
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W:0]      cand;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (bus.req_valid_i[cand[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  logic [NUM_REQ-1:0]  idx_onehot;
  logic [IDX_W-1:0]    next_ptr;
  logic [ADDR_W-1:0]   addr_aligned;

  assign idx_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q;
  assign next_ptr     = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
  assign addr_aligned = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    state_d             = state_q;
    rr_ptr_d            = rr_ptr_q;
    idx_d               = idx_q;
    rw_d                = rw_q;
    addr_d              = addr_q;
    data_d              = data_q;
    vc_hit_cnt_d        = vc_hit_cnt_q;
    bus.rsp_ready_o     = '0;
    bus.rsp_data_o      = '0;
    bus.grant_o         = '0;
    bus.vc_req_valid_o  = 1'b0;
    bus.vc_req_addr_o   = '0;
    bus.mem_req_valid_o = 1'b0;
    bus.mem_req_rw_o    = 1'b0;
    bus.mem_req_addr_o  = '0;
    bus.mem_req_data_o  = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          idx_d  = pick_idx;
          rw_d   = bus.req_rw_i[pick_idx];
          addr_d = req_addr[pick_idx];
          data_d = req_data[pick_idx];
          state_d = ((VC_EN != 0) && !bus.req_rw_i[pick_idx]) ? VC_LOOKUP : MEM;
        end
      end

      VC_LOOKUP: begin
        bus.grant_o        = idx_onehot;
        bus.vc_req_valid_o = 1'b1;
        bus.vc_req_addr_o  = addr_q;
        if (!bus.vc_miss_i) begin
          bus.rsp_ready_o = idx_onehot;
          bus.rsp_data_o  = bus.vc_rsp_data_i;
          if (vc_hit_cnt_q != 16'hFFFF) begin
            vc_hit_cnt_d = vc_hit_cnt_q + 16'd1;
          end
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end else begin
          state_d = MEM;
        end
      end

      MEM: begin
        bus.grant_o         = idx_onehot;
        bus.mem_req_valid_o = 1'b1;
        bus.mem_req_rw_o    = rw_q;
        bus.mem_req_addr_o  = addr_aligned;
        bus.mem_req_data_o  = data_q;
        if (bus.mem_rsp_ready_i) begin
          bus.rsp_ready_o = idx_onehot;
          // Writes complete with zero data so stale read data never leaks.
          bus.rsp_data_o  = rw_q ? '0 : bus.mem_rsp_data_i;
          rr_ptr_d        = next_ptr;
          state_d         = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      idx_q        <= '0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      vc_hit_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      idx_q        <= idx_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      vc_hit_cnt_q <= vc_hit_cnt_d;
    end
  end

  assign vc_hit_cnt_o = vc_hit_cnt_q;

endmodule

// File: tb/tb_cache_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_rr_arbiter
// Two arbiter instances (2 and 4 requesters) share one stimulus set; 'sel'
// chooses which one is observed. A transaction-level model predicts the
// winner, the path (VC hit / VC miss / write) and the expected bus values.
// ---------------------------------------------------------------------------
module tb_cache_rr_arbiter;
  logic clk;
  logic rst_n;
  logic sel;

  logic [7:0]   tb_valid;
  logic [7:0]   tb_rw;
  logic [31:0]  tb_addr [4];
  logic [127:0] tb_data [4];
  logic         vc_miss;
  logic [127:0] vc_rsp_data;
  logic         mem_rsp_ready;
  logic [127:0] mem_rsp_data;
  logic [15:0]  hit2, hit4;

  int n_tests = 0;
  int n_fail  = 0;

  cache_rr_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(128)) if2 ();
  cache_rr_arbiter_if #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(128)) if4 ();

  cache_rr_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(128), .OFF_W(4), .VC_EN(1)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .bus(if2), .vc_hit_cnt_o(hit2));
  cache_rr_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(128), .OFF_W(4), .VC_EN(1)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .bus(if4), .vc_hit_cnt_o(hit4));

  assign if2.req_valid_i     = tb_valid[1:0];
  assign if2.req_rw_i        = tb_rw[1:0];
  assign if2.req_addr_i      = {tb_addr[1], tb_addr[0]};
  assign if2.req_data_i      = {tb_data[1], tb_data[0]};
  assign if2.vc_miss_i       = vc_miss;
  assign if2.vc_rsp_data_i   = vc_rsp_data;
  assign if2.mem_rsp_ready_i = mem_rsp_ready;
  assign if2.mem_rsp_data_i  = mem_rsp_data;

  assign if4.req_valid_i     = tb_valid[3:0];
  assign if4.req_rw_i        = tb_rw[3:0];
  assign if4.req_addr_i      = {tb_addr[3], tb_addr[2], tb_addr[1], tb_addr[0]};
  assign if4.req_data_i      = {tb_data[3], tb_data[2], tb_data[1], tb_data[0]};
  assign if4.vc_miss_i       = vc_miss;
  assign if4.vc_rsp_data_i   = vc_rsp_data;
  assign if4.mem_rsp_ready_i = mem_rsp_ready;
  assign if4.mem_rsp_data_i  = mem_rsp_data;

  // observed view of the selected instance
  logic [7:0]   obs_grant, obs_rsp_ready;
  logic [127:0] obs_rsp_data, obs_mem_data;
  logic         obs_vc_valid, obs_mem_valid, obs_mem_rw;
  logic [31:0]  obs_vc_addr, obs_mem_addr;
  logic [15:0]  obs_hit_cnt;

  always_comb begin
    if (sel) begin
      obs_grant     = 8'(if4.grant_o);
      obs_rsp_ready = 8'(if4.rsp_ready_o);
      obs_rsp_data  = if4.rsp_data_o;
      obs_vc_valid  = if4.vc_req_valid_o;
      obs_vc_addr   = if4.vc_req_addr_o;
      obs_mem_valid = if4.mem_req_valid_o;
      obs_mem_rw    = if4.mem_req_rw_o;
      obs_mem_addr  = if4.mem_req_addr_o;
      obs_mem_data  = if4.mem_req_data_o;
      obs_hit_cnt   = hit4;
    end else begin
      obs_grant     = 8'(if2.grant_o);
      obs_rsp_ready = 8'(if2.rsp_ready_o);
      obs_rsp_data  = if2.rsp_data_o;
      obs_vc_valid  = if2.vc_req_valid_o;
      obs_vc_addr   = if2.vc_req_addr_o;
      obs_mem_valid = if2.mem_req_valid_o;
      obs_mem_rw    = if2.mem_req_rw_o;
      obs_mem_addr  = if2.mem_req_addr_o;
      obs_mem_data  = if2.mem_req_data_o;
      obs_hit_cnt   = hit2;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int          model_ptr;
  logic [15:0] model_hits;
  int          last_grant;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [7:0] v, input int ptr, input int n);
    for (int k = 0; k < n; k++) begin
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic randomize_requests(input int n);
    tb_valid = 8'($urandom_range(0, (1 << n) - 1));
    tb_rw    = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      tb_addr[k] = $urandom;
      tb_data[k] = rnd128();
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_idle_grant"}, obs_grant, 0);
    chk({tag, "_idle_rsp"}, obs_rsp_ready, 0);
    chk({tag, "_idle_rdata"}, obs_rsp_data, 0);
    chk({tag, "_idle_vc"}, obs_vc_valid, 0);
    chk({tag, "_idle_mem"}, obs_mem_valid, 0);
  endtask

  // One transaction starting in an idle cycle with requests already driven.
  task automatic do_txn(input string tag, input int n, input bit hit, input int stall,
                        input logic [127:0] vcd, input bit scramble);
    int w;
    logic rw;
    logic [31:0] addr;
    logic [127:0] data, memd;
    @(negedge clk);
    check_idle(tag);
    chk({tag, "_hits_pre"}, obs_hit_cnt, model_hits);
    w = model_pick(tb_valid, model_ptr, n);
    last_grant = w;
    if (w < 0) begin
      @(posedge clk); #1;
      return;
    end
    rw   = tb_rw[w];
    addr = tb_addr[w];
    data = tb_data[w];
    @(posedge clk); #1;
    if (scramble) randomize_requests(n);
    if (!rw) begin
      vc_miss       = !hit;
      vc_rsp_data   = vcd;
      mem_rsp_ready = 1'($urandom);
      mem_rsp_data  = rnd128();
      @(negedge clk);
      chk({tag, "_vc_valid"}, obs_vc_valid, 1);
      chk({tag, "_vc_addr"}, obs_vc_addr, addr);
      chk({tag, "_vc_grant"}, obs_grant, 8'(1 << w));
      chk({tag, "_vc_nomem"}, obs_mem_valid, 0);
      chk({tag, "_vc_rsp"}, obs_rsp_ready, hit ? 8'(1 << w) : 8'h0);
      if (hit) chk({tag, "_vc_rdata"}, obs_rsp_data, vcd);
      @(posedge clk); #1;
      vc_miss = 1'b0;
      mem_rsp_ready = 1'b0;
      if (hit) begin
        if (model_hits != 16'hFFFF) model_hits++;
        model_ptr = (w + 1) % n;
        chk({tag, "_hits"}, obs_hit_cnt, model_hits);
        return;
      end
    end
    memd = rnd128();
    for (int s = 0; s <= stall; s++) begin
      mem_rsp_ready = (s == stall);
      mem_rsp_data  = memd;
      vc_miss       = 1'($urandom);
      vc_rsp_data   = rnd128();
      @(negedge clk);
      chk({tag, "_mem_valid"}, obs_mem_valid, 1);
      chk({tag, "_mem_rw"}, obs_mem_rw, rw);
      chk({tag, "_mem_addr"}, obs_mem_addr, addr & 32'hFFFF_FFF0);
      chk({tag, "_mem_data"}, obs_mem_data, data);
      chk({tag, "_mem_novc"}, obs_vc_valid, 0);
      chk({tag, "_mem_grant"}, obs_grant, 8'(1 << w));
      chk({tag, "_mem_rsp"}, obs_rsp_ready, (s == stall) ? 8'(1 << w) : 8'h0);
      if (s == stall) chk({tag, "_mem_rdata"}, obs_rsp_data, rw ? 128'h0 : memd);
      @(posedge clk); #1;
    end
    mem_rsp_ready = 1'b0;
    vc_miss = 1'b0;
    model_ptr = (w + 1) % n;
    chk({tag, "_hits"}, obs_hit_cnt, model_hits);
  endtask

  initial begin
    sel = 1'b0;
    rst_n = 1'b0;
    tb_valid = '0;
    tb_rw = '0;
    for (int k = 0; k < 4; k++) begin
      tb_addr[k] = '0;
      tb_data[k] = '0;
    end
    vc_miss = 1'b0;
    vc_rsp_data = '0;
    mem_rsp_ready = 1'b0;
    mem_rsp_data = '0;
    model_ptr = 0;
    model_hits = '0;
    last_grant = -1;

    // reset state (valid requests present but held in reset)
    tb_valid = 8'h03;
    @(negedge clk);
    check_idle("reset");
    chk("reset_hits", obs_hit_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // both requesters read together, VC misses, memory stalls 3 cycles
    tb_valid = 8'h03; tb_rw = 8'h00;
    tb_addr[0] = 32'h1004; tb_addr[1] = 32'h2008;
    tb_data[0] = rnd128(); tb_data[1] = rnd128();
    do_txn("pair_a", 2, 1'b0, 3, 128'h0, 1'b0);
    chk("pair_first", last_grant, 0);
    do_txn("pair_b", 2, 1'b0, 3, 128'h0, 1'b0);
    chk("pair_second", last_grant, 1);
    $display("[TB] pair reads served in order %0d,1", 0);

    // requester 1 read hits in the victim cache
    tb_valid = 8'h02; tb_rw = 8'h00; tb_addr[1] = 32'h40;
    do_txn("vc_hit", 2, 1'b1, 0, 128'hAB, 1'b0);
    chk("vc_hit_grant", last_grant, 1);
    chk("vc_hit_cnt1", obs_hit_cnt, 16'd1);
    $display("[TB] vc hit to requester 1, hit count %0d", obs_hit_cnt);

    // write, no lookup, five stall cycles, requester inputs change mid-flight
    tb_valid = 8'h01; tb_rw = 8'h01; tb_addr[0] = 32'h10F; tb_data[0] = 128'hDEAD;
    do_txn("write", 2, 1'b0, 5, 128'h0, 1'b1);
    chk("write_grant", last_grant, 0);
    $display("[TB] write 0xDEAD to 0x10F completed");

    // reset asserted during MEM (rr_ptr is 1 at this point)
    tb_valid = 8'h02; tb_rw = 8'h00; tb_addr[1] = 32'h3000_0024;
    @(negedge clk);
    chk("rst_pre_idle", obs_grant, 0);
    @(posedge clk); #1;
    vc_miss = 1'b1;
    @(negedge clk);
    chk("rst_lookup", obs_vc_valid, 1);
    @(posedge clk); #1;
    vc_miss = 1'b0;
    @(negedge clk);
    chk("rst_in_mem", obs_mem_valid, 1);
    chk("rst_in_mem_grant", obs_grant, 8'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_mem", obs_mem_valid, 0);
    chk("rst_async_addr", obs_mem_addr, 0);
    chk("rst_async_grant", obs_grant, 0);
    chk("rst_async_rsp", obs_rsp_ready, 0);
    chk("rst_async_hits", obs_hit_cnt, 0);
    mem_rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_no_pulse", obs_rsp_ready, 0);
    chk("rst_held_mem", obs_mem_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rsp_ready = 1'b0;
    model_ptr = 0;
    model_hits = '0;
    tb_valid = 8'h03; tb_rw = 8'h03;
    do_txn("post_rst", 2, 1'b0, 1, 128'h0, 1'b0);
    chk("post_rst_grant", last_grant, 0);
    $display("[TB] reset during MEM, first grant %0d", last_grant);

    // switch to the 4-requester instance
    tb_valid = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sel = 1'b1;
    model_ptr = 0;
    model_hits = '0;

    // all four valid continuously: strict rotation
    tb_valid = 8'h0F;
    for (int t = 0; t < 8; t++) begin
      tb_rw = 8'($urandom);
      for (int k = 0; k < 4; k++) begin
        tb_addr[k] = $urandom;
        tb_data[k] = rnd128();
      end
      do_txn("rr", 4, 1'($urandom), $urandom_range(0, 2), rnd128(), 1'b0);
      chk("rr_order", last_grant, t % 4);
      $display("[TB] rr transaction %0d granted %0d", t, last_grant);
    end

    // randomized traffic against the model
    for (int t = 0; t < 200; t++) begin
      randomize_requests(4);
      do_txn("rand", 4, 1'($urandom), $urandom_range(0, 3), rnd128(), 1'b1);
      $display("[TB] random transaction %0d granted %0d", t, last_grant);
    end

    // hit-counter saturation: preload near the top instead of 65536 hits
    tb_valid = '0;
    force dut4.vc_hit_cnt_d = 16'hFFFC;
    @(posedge clk); #1;
    release dut4.vc_hit_cnt_d;
    model_hits = 16'hFFFC;
    for (int t = 0; t < 5; t++) begin
      tb_valid = 8'(1 << $urandom_range(0, 3));
      tb_rw = '0;
      do_txn("sat", 4, 1'b1, 0, rnd128(), 1'b0);
      $display("[TB] saturation hit %0d, count %0h", t, obs_hit_cnt);
    end
    chk("sat_hold", obs_hit_cnt, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_rr_arbiter.md
CACHE_RR_ARBITER -- requirements
Module: cache_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of L1 requesters; legal range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 32: request address width.
REQ-003 SHALL have parameter DATA_W, default 128: block data width.
REQ-004 SHALL have parameter OFF_W, default 4: block-offset bits cleared on downstream addresses.
REQ-005 SHALL have parameter VC_EN, default 1: 1 = victim-cache lookup precedes memory for reads; 0 = no lookup.
REQ-006 SHALL have port clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_ni  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port req_valid_i  in  NUM_REQ  per-requester request valid.
REQ-009 SHALL have port req_rw_i  in  NUM_REQ  per-requester direction; 1 = write.
REQ-010 SHALL have port req_addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester k occupies slice k.
REQ-011 SHALL have port req_data_i  in  NUM_REQ*DATA_W  packed write data.
REQ-012 SHALL have port rsp_ready_o  out  NUM_REQ  one-cycle completion pulse per requester.
REQ-013 SHALL have port rsp_data_o  out  DATA_W  response data; valid only while a rsp_ready_o bit is 1.
REQ-014 SHALL have port vc_req_valid_o  out  1  victim-cache lookup strobe.
REQ-015 SHALL have port vc_req_addr_o  out  ADDR_W  lookup address, unaligned.
REQ-016 SHALL have port vc_miss_i  in  1  victim-cache miss, same-cycle response to the lookup.
REQ-017 SHALL have port vc_rsp_data_i  in  DATA_W  victim-cache hit data.
REQ-018 SHALL have port mem_req_valid_o, mem_req_rw_o  out  1 each  L2 request valid and direction.
REQ-019 SHALL have port mem_req_addr_o  out  ADDR_W  L2 address, low OFF_W bits zero.
REQ-020 SHALL have port mem_req_data_o  out  DATA_W  L2 write data.
REQ-021 SHALL have port mem_rsp_ready_i  in  1  L2 completion.
REQ-022 SHALL have port mem_rsp_data_i  in  DATA_W  L2 read data.
REQ-023 SHALL have port grant_o  out  NUM_REQ  one-hot owner of the in-flight transaction; zero in IDLE.
REQ-024 SHALL have port vc_hit_cnt_o  out  16  saturating count of victim-cache hits.

Function
REQ-025 SHALL implement the states IDLE, VC_LOOKUP and MEM.
REQ-026 In IDLE, the block SHALL grant the first valid requester at or after rr_ptr, searching upward with wrap.
- On a grant, the block SHALL latch the index, rw, addr and data of the granted requester.
REQ-027 After a grant, the next state SHALL be VC_LOOKUP if VC_EN=1 and rw=0; otherwise it SHALL be MEM.
REQ-028 VC_LOOKUP SHALL last exactly one cycle.
- vc_req_valid_o=1, with vc_req_addr_o = the latched address.
- If vc_miss_i=0: pulse rsp_ready_o[idx] with rsp_data_o=vc_rsp_data_i, then go to IDLE.
- If vc_miss_i=1: go to MEM.
REQ-029 In MEM, the block SHALL hold mem_req_valid_o=1 with rw/addr/data stable until mem_rsp_ready_i=1.
- In that cycle: pulse rsp_ready_o[idx]; for reads, rsp_data_o=mem_rsp_data_i, for writes rsp_data_o=0; then go to IDLE.
REQ-030 On every completion, rr_ptr SHALL become (idx+1) mod NUM_REQ.
REQ-031 Latency SHALL be as follows:
- A VC hit responds 1 cycle after the granting edge.
- A miss or a write issues its memory request 1 or 2 cycles after the grant.
- At least one IDLE cycle SHALL separate any two transactions.
REQ-032 Latched fields SHALL be immune to requester input changes after the grant; a requester dropping valid mid-transaction SHALL NOT abort it, and its pulse SHALL still be issued.
REQ-033 When idle, all request and response outputs SHALL be 0; rsp_ready_o SHALL never have more than one bit set.
REQ-034 vc_hit_cnt_o SHALL increment on each VC hit and hold at 16'hFFFF.

Reset
REQ-035 While rst_ni=0, asynchronously: state=IDLE, rr_ptr=0, latched fields=0, vc_hit_cnt_o=0, every output 0.
REQ-036 A reset asserted mid-transaction SHALL discard it; no response pulse SHALL follow, and after release the block SHALL restart in IDLE from requester 0.

Verification
REQ-037 A bench SHALL cover: NUM_REQ=2, both requesters read addr 0x1004/0x2008 together, vc_miss_i=1, mem_rsp_ready_i after 3 cycles -> requester 0 is served first with mem addr 0x1000, then requester 1 with 0x2000.
REQ-038 A bench SHALL cover: requester 1 reads 0x40, vc_miss_i=0, vc_rsp_data_i=0xAB -> rsp_ready_o=2'b10 one cycle after the grant with data 0xAB, no memory request, and vc_hit_cnt_o=1.
REQ-039 A bench SHALL cover: NUM_REQ=4, all requesters valid continuously, for 8 transactions -> grants 0,1,2,3,0,1,2,3.
REQ-040 A bench SHALL cover: a write of 0xDEAD to 0x10F -> no lookup; mem_req_rw_o=1, addr=0x100, data=0xDEAD, held stable through 5 stall cycles.
REQ-041 A bench SHALL cover: rst_ni driven low during MEM -> outputs 0 immediately, no rsp_ready_o pulse, and the first post-reset grant goes to requester 0.
REQ-042 A bench SHALL cover: 65536 consecutive VC hits -> vc_hit_cnt_o saturates at 0xFFFF.
